// File: rtl/demux_1x16.sv
// 1-to-16 serial demux with per-channel hold register and valid/ack handshake.
// Optional refused-transfer counter (drop_cnt) when DEMUX_1X16_STATS_EN is defined.
module demux_1x16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        d,
   input  logic [3:0]  s,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] y,
   output logic [15:0] y_valid,
   input  logic [15:0] y_ack,
   output logic [4:0]  occ
`ifdef DEMUX_1X16_STATS_EN
   ,
   output logic [7:0]  drop_cnt
`endif
);

   logic [15:0] y_r;
   logic [15:0] y_valid_r;
   logic [4:0]  occ_r;
   logic [15:0] sel_s;
   logic [15:0] wr_s;
   logic        accept_s;
   logic [15:0] y_next_s;
   logic [15:0] valid_next_s;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

   // Slot is free when empty or being drained this cycle.
   assign in_ready = ~y_valid_r[s] | y_ack[s];
   assign accept_s = in_valid & in_ready;

   // Select decode, write mask and next-state channel contents.
   always_comb begin
      sel_s        = 16'h0000;
      sel_s[s]     = 1'b1;
      if (accept_s) begin
         wr_s = sel_s;
      end else begin
         wr_s = 16'h0000;
      end
      // Write wins over a same-cycle ack on the written channel.
      valid_next_s = (y_valid_r & ~y_ack) | wr_s;
      y_next_s     = (y_r & ~wr_s) | (wr_s & {16{d}});
   end

   // Channel data, pending flags and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_r       <= 16'h0000;
         y_valid_r <= 16'h0000;
         occ_r     <= 5'd0;
      end else begin
         y_r       <= y_next_s;
         y_valid_r <= valid_next_s;
         occ_r     <= popcount16(valid_next_s);
      end
   end

   assign y       = y_r;
   assign y_valid = y_valid_r;
   assign occ     = occ_r;

`ifdef DEMUX_1X16_STATS_EN
   logic [7:0] drop_cnt_r;

   // Saturating count of stalled (refused) transfer cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_r <= 8'd0;
      end else if (in_valid && !in_ready && (drop_cnt_r != 8'hFF)) begin
         drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_demux_1x16.sv
// Directed self-checking bench for demux_1x16; define DEMUX_1X16_STATS_EN to cover drop_cnt.
module tb_demux_1x16;

   logic        clk;
   logic        rst;
   logic        d;
   logic [3:0]  s;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] y;
   logic [15:0] y_valid;
   logic [15:0] y_ack;
   logic [4:0]  occ;
`ifdef DEMUX_1X16_STATS_EN
   logic [7:0]  drop_cnt;
`endif

   int checks;
   int failures;

   demux_1x16 dut (
      .clk      (clk),
      .rst      (rst),
      .d        (d),
      .s        (s),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y        (y),
      .y_valid  (y_valid),
      .y_ack    (y_ack),
      .occ      (occ)
`ifdef DEMUX_1X16_STATS_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_ch(input logic [3:0] k, input logic dv);
      s        = k;
      d        = dv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      d        = 1'b0;
      s        = 4'd0;
      in_valid = 1'b0;
      y_ack    = 16'h0000;

      #2;
      check("rst_y", {16'h0, y}, 32'h0);
      check("rst_yv", {16'h0, y_valid}, 32'h0);
      check("rst_occ", {27'h0, occ}, 32'h0);
      check("rst_rdy", {31'h0, in_ready}, 32'h1);
`ifdef DEMUX_1X16_STATS_EN
      check("rst_drop", {24'h0, drop_cnt}, 32'h0);
`endif
      step();
      rst = 1'b1;

      // Routing to channel 5
      s = 4'd5; d = 1'b1; in_valid = 1'b1;
      #1;
      check("route_rdy", {31'h0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      check("route_y", {16'h0, y}, 32'h0020);
      check("route_yv", {16'h0, y_valid}, 32'h0020);
      check("route_occ", {27'h0, occ}, 32'd1);

      // Backpressure on channel 9
      write_ch(4'd9, 1'b1);
      check("bp_fill_yv", {16'h0, y_valid}, 32'h0220);
      s = 4'd9; d = 1'b0; in_valid = 1'b1;
      #1;
      check("bp_rdy", {31'h0, in_ready}, 32'h0);
      step();
      step();
      check("bp_y_held", {16'h0, y}, 32'h0220);
      check("bp_yv_held", {16'h0, y_valid}, 32'h0220);
      check("bp_occ", {27'h0, occ}, 32'd2);
`ifdef DEMUX_1X16_STATS_EN
      check("bp_drop", {24'h0, drop_cnt}, 32'd2);
`endif
      in_valid = 1'b0;
      #1;
      check("rdy_no_valid", {31'h0, in_ready}, 32'h0);

      // Ack on an empty channel is ignored
      y_ack = 16'h0001;
      step();
      y_ack = 16'h0000;
      check("ack_empty_yv", {16'h0, y_valid}, 32'h0220);

      // Drain 5 and 9: data held after flag clears
      y_ack = 16'h0220;
      step();
      y_ack = 16'h0000;
      check("drain_yv", {16'h0, y_valid}, 32'h0);
      check("drain_occ", {27'h0, occ}, 32'd0);
      check("drain_y", {16'h0, y}, 32'h0220);

      // Simultaneous write and ack on channel 3
      write_ch(4'd3, 1'b0);
      check("sim_pre_yv", {16'h0, y_valid}, 32'h0008);
      s = 4'd3; d = 1'b1; in_valid = 1'b1; y_ack = 16'h0008;
      #1;
      check("sim_rdy", {31'h0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0; y_ack = 16'h0000;
      check("sim_y", {16'h0, y}, 32'h0228);
      check("sim_yv", {16'h0, y_valid}, 32'h0008);
      check("sim_occ", {27'h0, occ}, 32'd1);

      // Fill all channels with d = k[0], then drain all
      y_ack = 16'h0008;
      step();
      y_ack = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         write_ch(k[3:0], k[0]);
      end
      check("fill_occ", {27'h0, occ}, 32'd16);
      check("fill_y", {16'h0, y}, 32'hAAAA);
      check("fill_yv", {16'h0, y_valid}, 32'hFFFF);
      y_ack = 16'hFFFF;
      step();
      y_ack = 16'h0000;
      check("empty_yv", {16'h0, y_valid}, 32'h0);
      check("empty_occ", {27'h0, occ}, 32'd0);
      check("empty_y", {16'h0, y}, 32'hAAAA);

      // Asynchronous reset with every channel full
      for (int k = 0; k < 16; k++) begin
         write_ch(k[3:0], 1'b1);
      end
      check("full_yv", {16'h0, y_valid}, 32'hFFFF);
      s = 4'd2; d = 1'b1; in_valid = 1'b1; y_ack = 16'hFFFF;
      #2;
      rst = 1'b0;
      #1;
      check("async_y", {16'h0, y}, 32'h0);
      check("async_yv", {16'h0, y_valid}, 32'h0);
      check("async_occ", {27'h0, occ}, 32'd0);
      step();
      check("inrst_yv", {16'h0, y_valid}, 32'h0);
      rst = 1'b1; in_valid = 1'b0; y_ack = 16'h0000;
      step();
      check("post_rst_yv", {16'h0, y_valid}, 32'h0);
      write_ch(4'd7, 1'b1);
      check("resume_y", {16'h0, y}, 32'h0080);
      check("resume_occ", {27'h0, occ}, 32'd1);

`ifdef DEMUX_1X16_STATS_EN
      // Saturation of drop_cnt
      check("sat_start", {24'h0, drop_cnt}, 32'd0);
      s = 4'd7; d = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("sat_10", {24'h0, drop_cnt}, 32'd10);
      for (int i = 0; i < 290; i++) step();
      check("sat_300", {24'h0, drop_cnt}, 32'd255);
      for (int i = 0; i < 5; i++) step();
      check("sat_hold", {24'h0, drop_cnt}, 32'd255);
      check("sat_y", {16'h0, y}, 32'h0080);
      in_valid = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
